dea_stream: RTL and testbench
=============================

# dea_stream

Parametrised byte-stream XOR cipher. It is the multi-byte-key, flow-controlled successor of the single-byte DEA datapath. A key of KEY_BYTES words is loaded serially over the shared data input. Each accepted data word is XORed with the current key word, and the key index rotates after every word. Both sides use a valid/ready handshake with a single registered output stage. The block sits between the byte-stream source and the transmit/storage path.

## Interface
- DATA_W, 8, width of data and of each key word
- KEY_BYTES, 4, number of key words (≥1); key index width IDX_W = max(1, $clog2(KEY_BYTES))
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-low reset (reset==0 at a rising edge resets the block)
- kset  in  1  qualifies the current input beat as a key word (1) or a data word (0)
- mode  in  1  0 = encrypt, 1 = decrypt; sampled per accepted data beat; only meaningful with DEA_CHAIN_EN
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept a beat
- din  in  DATA_W  key word or data word
- dout  out  DATA_W  result word
- out_valid  out  1  dout valid
- out_ready  in  1  downstream accepts dout
- key_loaded  out  1  high in state RUN
- key_err  out  1  sticky: a data beat arrived with no complete key

## Operation
- Beat accepted when in_valid && in_ready.
- in_ready = !out_valid || out_ready. The same rule applies to key beats, so key loading stalls under backpressure.
- States:
  - NOKEY (reset state).
    - Key beat: write key[0], idx←1, go to LOAD. If KEY_BYTES==1, go to RUN instead, with idx←0.
    - Data beat: consumed and discarded, key_err←1.
  - LOAD.
    - Key beat: write key[idx]. On idx==KEY_BYTES-1, set idx←0 and go to RUN; otherwise idx←idx+1.
    - Data beat: discarded, key_err←1, stay in LOAD, idx unchanged.
  - RUN.
    - Data beat: dout←din^key[idx], out_valid←1, idx←(idx==KEY_BYTES-1)?0:idx+1.
    - Key beat: start a reload. Write key[0], idx←1, go to LOAD (or stay in RUN with idx←0 if KEY_BYTES==1). A pending output word is unaffected.
- Output register:
  - out_valid clears when out_ready && out_valid && no new data beat is accepted in the same cycle.
  - dout holds its value while out_valid && !out_ready.
- key_err clears only on reset.
- A partial reload leaves the old key words in positions not yet rewritten. The block stays in LOAD until the full count is reached.
- Reset values: dout=0, out_valid=0, in_ready=1, key_loaded=0, key_err=0, state NOKEY, idx=0, all key words 0.

## Timing
- Latency is 1 cycle: a data beat accepted at edge N gives out_valid=1 and a valid dout after edge N.
- Throughput is 1 word/cycle with out_ready held high.
- Output consumed and new data accepted at the same edge: out_valid stays 1 and dout updates.
- key_loaded rises the cycle after the last key beat is accepted. The first data beat may be accepted in that next cycle.
- Reset mid-operation drops any pending output word and any partial key. The state after reset equals the reset state listed above.
- The idx wrap from KEY_BYTES-1 to 0 happens at the same edge as the XOR, with no bubble.

## Configuration
- DEA_CHAIN_EN defined (autokey chaining): after each RUN data beat, key[idx_used] is overwritten.
  - Encrypt (mode=0): overwrite with the produced ciphertext (din^key).
  - Decrypt (mode=1): overwrite with the incoming ciphertext din.
  - Decrypting with the same initial key therefore inverts encryption.
- DEA_CHAIN_EN undefined: the key is static between loads, mode is ignored, and there is no key write path from the datapath.

## Test plan
- Static XOR: DATA_W=8, KEY_BYTES=4, no chain. Load key 0x11,0x22,0x33,0x44, then send data 0xAA ×5. Required dout: 0xBB,0x88,0x99,0xEE,0xBB.
- Chained encrypt (DEA_CHAIN_EN): same key, mode=0, data 0x01 ×5. Required dout: 0x10,0x23,0x32,0x45,0x11. Without the macro the fifth word is 0x10.
- Chained decrypt (DEA_CHAIN_EN): reload the same key, mode=1, data 0x10,0x23,0x32,0x45,0x11. Required dout: 0x01 ×5.
- Backpressure: with out_valid=1, hold out_ready=0 for 3 cycles while in_valid=1. Required: in_ready=0 and dout stable for 3 cycles. After out_ready=1, the next word follows with no loss.
- Data before key: from reset, send data 0x55 with kset=0. Required: beat accepted, out_valid stays 0, key_err=1 until reset.
- Reset mid-stream: drive reset=0 for one edge with out_valid=1 in RUN. Required next cycle: out_valid=0, key_loaded=0, dout=0. A subsequent data beat sets key_err.

Source files
------------

// File: rtl/dea_stream.sv
// dea_stream: byte-stream XOR cipher with a multi-word key and valid/ready flow control.
//
// A key of KEY_BYTES words is loaded serially over din (kset=1). Each data word
// (kset=0) accepted in RUN is XORed with key[idx], and idx rotates after every word.
// There is a single registered output stage. in_ready is a combinational function
// of the output register and out_ready, so key loading also stalls under backpressure.
//
// Optional feature macro: DEA_CHAIN_EN
//   defined   - autokey chaining: after each data word, key[idx_used] is overwritten
//               with the ciphertext (din^key when mode=0, din when mode=1).
//   undefined - the key is static between loads and mode is ignored.
//
// Ports:
//   clk         in   clock, rising edge
//   reset       in   synchronous active-low reset
//   kset        in   1 = key word beat, 0 = data word beat
//   mode        in   0 = encrypt, 1 = decrypt (used only with DEA_CHAIN_EN)
//   in_valid    in   input beat valid
//   in_ready    out  block can accept a beat
//   din         in   key or data word
//   dout        out  result word
//   out_valid   out  dout valid
//   out_ready   in   downstream accepts dout
//   key_loaded  out  high while a complete key is held (state RUN)
//   key_err     out  sticky: a data beat arrived with no complete key

module dea_stream #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned KEY_BYTES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              kset,
  input  logic              mode,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              key_loaded,
  output logic              key_err
);

  localparam int unsigned IDX_W = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(KEY_BYTES - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  typedef enum logic [1:0] {
    ST_NOKEY = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  // Registers
  state_t              r_state;
  logic [IDX_W-1:0]    r_idx;
  logic [DATA_W-1:0]   r_key [KEY_BYTES];
  logic [DATA_W-1:0]   r_dout;
  logic                r_out_valid;
  logic                r_key_err;

  // Next-state values
  state_t              w_state_nxt;
  logic [IDX_W-1:0]    w_idx_nxt;
  logic [DATA_W-1:0]   w_key_nxt [KEY_BYTES];
  logic [DATA_W-1:0]   w_dout_nxt;
  logic                w_out_valid_nxt;
  logic                w_key_err_nxt;

  // Datapath helpers
  logic                w_in_ready;
  logic                w_accept;
  logic                w_idx_last;
  logic [DATA_W-1:0]   w_key_word;
  logic [DATA_W-1:0]   w_xor;

`ifndef DEA_CHAIN_EN
  // mode has no effect without chaining; keep it visibly consumed.
  logic w_unused;
  assign w_unused = mode;
`endif

  // Handshake: the output stage frees up when empty or being drained this cycle.
  assign w_in_ready = !r_out_valid || out_ready;
  assign w_accept   = in_valid && w_in_ready;
  assign w_idx_last = (r_idx == IDX_LAST);
  assign w_key_word = r_key[r_idx];
  assign w_xor      = din ^ w_key_word;

  // Output mapping
  assign in_ready   = w_in_ready;
  assign dout       = r_dout;
  assign out_valid  = r_out_valid;
  assign key_loaded = (r_state == ST_RUN);
  assign key_err    = r_key_err;

  // Next-state, key update and output stage logic
  always_comb begin
    w_state_nxt     = r_state;
    w_idx_nxt       = r_idx;
    w_key_nxt       = r_key;
    w_dout_nxt      = r_dout;
    w_out_valid_nxt = r_out_valid;
    w_key_err_nxt   = r_key_err;

    // Drain the output word; a new data beat below re-asserts valid.
    if (r_out_valid && out_ready) begin
      w_out_valid_nxt = 1'b0;
    end

    if (w_accept) begin
      if (kset) begin
        unique case (r_state)
          ST_NOKEY, ST_RUN: begin
            // First key word of a load or reload; a pending output is untouched.
            w_key_nxt[0] = din;
            if (KEY_BYTES == 1) begin
              w_state_nxt = ST_RUN;
              w_idx_nxt   = '0;
            end else begin
              w_state_nxt = ST_LOAD;
              w_idx_nxt   = IDX_ONE;
            end
          end
          ST_LOAD: begin
            w_key_nxt[r_idx] = din;
            if (w_idx_last) begin
              w_state_nxt = ST_RUN;
              w_idx_nxt   = '0;
            end else begin
              w_idx_nxt   = r_idx + IDX_ONE;
            end
          end
          default: begin
            w_state_nxt = ST_NOKEY;
            w_idx_nxt   = '0;
          end
        endcase
      end else begin
        if (r_state == ST_RUN) begin
          w_dout_nxt      = w_xor;
          w_out_valid_nxt = 1'b1;
          w_idx_nxt       = w_idx_last ? '0 : (r_idx + IDX_ONE);
`ifdef DEA_CHAIN_EN
          // Autokey: feed the ciphertext back into the key slot just used.
          w_key_nxt[r_idx] = mode ? din : w_xor;
`endif
        end else begin
          // Data without a complete key is consumed and flagged.
          w_key_err_nxt = 1'b1;
        end
      end
    end
  end

  // Register update with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= ST_NOKEY;
      r_idx       <= '0;
      r_dout      <= '0;
      r_out_valid <= 1'b0;
      r_key_err   <= 1'b0;
      for (int i = 0; i < int'(KEY_BYTES); i++) begin
        r_key[i] <= '0;
      end
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_dout      <= w_dout_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_key_err   <= w_key_err_nxt;
      r_key       <= w_key_nxt;
    end
  end

endmodule

// File: tb/tb_dea_stream.sv
// tb_dea_stream: directed self-checking bench for dea_stream (DATA_W=8, KEY_BYTES=4).
// Expected values are hand-computed; chained-mode expectations apply when
// DEA_CHAIN_EN is defined for the build.

module tb_dea_stream;

  logic       clk;
  logic       reset;
  logic       kset;
  logic       mode;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] din;
  logic [7:0] dout;
  logic       out_valid;
  logic       out_ready;
  logic       key_loaded;
  logic       key_err;

  int n_checks;
  int n_errors;

  dea_stream #(
    .DATA_W    (8),
    .KEY_BYTES (4)
  ) u_dut (
    .clk        (clk),
    .reset      (reset),
    .kset       (kset),
    .mode       (mode),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .din        (din),
    .dout       (dout),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .key_loaded (key_loaded),
    .key_err    (key_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // One edge with reset low, then release; returns 1 time unit after the edge.
  task automatic do_reset();
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  // Present one beat for one edge; returns 1 time unit after that edge.
  task automatic send(input logic k, input logic [7:0] d, input logic m);
    kset     = k;
    din      = d;
    mode     = m;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic load_key();
    send(1'b1, 8'h11, 1'b0);
    send(1'b1, 8'h22, 1'b0);
    send(1'b1, 8'h33, 1'b0);
    send(1'b1, 8'h44, 1'b0);
  endtask

  logic [7:0] exp_a [5];
  logic [7:0] exp_e [5];
  logic [7:0] exp_d [5];
  logic [7:0] dec_in [5];

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    reset     = 1'b1;
    kset      = 1'b0;
    mode      = 1'b0;
    in_valid  = 1'b0;
    din       = 8'h00;
    out_ready = 1'b1;

    exp_a  = '{8'hBB, 8'h88, 8'h99, 8'hEE, 8'hBB};
    exp_e  = '{8'h10, 8'h23, 8'h32, 8'h45, 8'h10};
    exp_d  = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h00};
    dec_in = '{8'h10, 8'h23, 8'h32, 8'h45, 8'h11};
`ifdef DEA_CHAIN_EN
    exp_a[4] = 8'h11;
    exp_e[4] = 8'h11;
    exp_d[4] = 8'h01;
`endif

    @(posedge clk);
    #1;
    do_reset();

    // Reset state
    check_eq("rst_dout", 32'(dout), 32'h00);
    check_eq("rst_out_valid", 32'(out_valid), 32'h0);
    check_eq("rst_in_ready", 32'(in_ready), 32'h1);
    check_eq("rst_key_loaded", 32'(key_loaded), 32'h0);
    check_eq("rst_key_err", 32'(key_err), 32'h0);

    // Data before key: consumed, no output, sticky error
    send(1'b0, 8'h55, 1'b0);
    check_eq("nokey_out_valid", 32'(out_valid), 32'h0);
    check_eq("nokey_key_err", 32'(key_err), 32'h1);
    @(posedge clk);
    #1;
    check_eq("nokey_err_sticky", 32'(key_err), 32'h1);
    do_reset();
    check_eq("nokey_err_clr", 32'(key_err), 32'h0);

    // Key load: key_loaded only after the last word
    send(1'b1, 8'h11, 1'b0);
    send(1'b1, 8'h22, 1'b0);
    send(1'b1, 8'h33, 1'b0);
    check_eq("load_partial", 32'(key_loaded), 32'h0);
    send(1'b1, 8'h44, 1'b0);
    check_eq("load_done", 32'(key_loaded), 32'h1);

    // Static XOR stream (back-to-back)
    for (int i = 0; i < 5; i++) begin
      send(1'b0, 8'hAA, 1'b0);
      check_eq($sformatf("xor_aa_%0d", i), 32'(dout), 32'(exp_a[i]));
      check_eq($sformatf("xor_aa_v%0d", i), 32'(out_valid), 32'h1);
    end

    // Encrypt 0x01 x5 after a reload in RUN
    load_key();
    check_eq("reload_done", 32'(key_loaded), 32'h1);
    for (int i = 0; i < 5; i++) begin
      send(1'b0, 8'h01, 1'b0);
      check_eq($sformatf("enc_%0d", i), 32'(dout), 32'(exp_e[i]));
    end

    // Decrypt with the same initial key
    load_key();
    for (int i = 0; i < 5; i++) begin
      send(1'b0, dec_in[i], 1'b1);
      check_eq($sformatf("dec_%0d", i), 32'(dout), 32'(exp_d[i]));
    end

    // Backpressure: hold output, stall input for 3 cycles
    load_key();
    send(1'b0, 8'hAA, 1'b0);
    check_eq("bp_first", 32'(dout), 32'hBB);
    out_ready = 1'b0;
    kset      = 1'b0;
    mode      = 1'b0;
    din       = 8'h0F;
    in_valid  = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("bp_in_ready_%0d", i), 32'(in_ready), 32'h0);
      check_eq($sformatf("bp_dout_%0d", i), 32'(dout), 32'hBB);
      check_eq($sformatf("bp_valid_%0d", i), 32'(out_valid), 32'h1);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check_eq("bp_next_dout", 32'(dout), 32'h2D);
    check_eq("bp_next_valid", 32'(out_valid), 32'h1);
    @(posedge clk);
    #1;
    check_eq("bp_drained", 32'(out_valid), 32'h0);

    // Reset mid-stream with a pending output word
    send(1'b0, 8'h77, 1'b0);
    check_eq("mid_pending", 32'(out_valid), 32'h1);
    do_reset();
    check_eq("mid_out_valid", 32'(out_valid), 32'h0);
    check_eq("mid_key_loaded", 32'(key_loaded), 32'h0);
    check_eq("mid_dout", 32'(dout), 32'h00);
    check_eq("mid_key_err0", 32'(key_err), 32'h0);
    send(1'b0, 8'h55, 1'b0);
    check_eq("mid_key_err1", 32'(key_err), 32'h1);
    check_eq("mid_no_out", 32'(out_valid), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
